// File: rtl/dataout_arbiter.sv
// -----------------------------------------------------------------------------
// dataout_arbiter
//
// Purpose
//   Collects bytes from NUM_CH requester channels into a DEPTH-entry output
//   FIFO and hands them to a single consumer. A three-state controller
//   (IDLE / RUN / DRAIN) gates arbitration. Grants are issued only in RUN.
//   Grant selection is round-robin, starting after the last granted channel.
//
// Handshakes (valid/ready semantics)
//   Requester side:
//     - A channel raises req_valid[i] and holds req_data[8i+7:8i] stable.
//     - It keeps both stable until req_gnt[i] is high in a cycle.
//     - The byte is taken on the rising edge that ends that cycle.
//     - req_gnt is combinational.
//     - At most one bit of req_gnt is high in any cycle.
//     - A bit is never high for a channel whose req_valid bit is clear.
//   Consumer side:
//     - ready is high whenever the FIFO holds at least one byte.
//     - While ready is high, data_out shows the head byte.
//     - A pop happens on any rising edge where read and ready are both high.
//     - A read while ready is low changes nothing.
//     - Such a read is flagged by a one-cycle rd_err pulse in the next cycle.
//
// Ports
//   clk        in   1          sole clock, rising edge
//   rst        in   1          asynchronous, active-high reset
//   en         in   1          arbitration enable (level)
//   req_valid  in   NUM_CH     per-channel request
//   req_data   in   NUM_CH*8   per-channel byte, channel i at [8i+7:8i]
//   req_gnt    out  NUM_CH     one-hot grant, combinational
//   ready      out  1          FIFO non-empty
//   read       in   1          consumer pop strobe
//   data_out   out  8          FIFO head (holds last value when empty)
//   busy       out  1          controller in RUN or DRAIN
//   fifo_count out  log2(D)+1  FIFO occupancy
//   rd_err     out  1          read-while-empty pulse
//   dbg_state  out  2          controller state (0 IDLE, 1 RUN, 2 DRAIN)
// -----------------------------------------------------------------------------
module dataout_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*8-1:0]      req_data,
  output logic [NUM_CH-1:0]        req_gnt,
  output logic                     ready,
  input  logic                     read,
  output logic [7:0]               data_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     rd_err,
  output logic [1:0]               dbg_state
);

  localparam int PW   = $clog2(DEPTH);
  localparam int IDXW = $clog2(NUM_CH);
  localparam logic [PW:0]     L_DEPTH    = (PW+1)'(DEPTH);
  localparam logic [IDXW-1:0] L_LAST_CH  = IDXW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PW:0]     r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [IDXW-1:0] r_last;
  logic [7:0]      r_hold;
  logic            r_rd_err;
  logic [7:0]      r_mem [DEPTH];

  logic            w_ready;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_found;
  logic            w_push;
  int              w_cand;
  logic [IDXW-1:0] w_gnt_idx;
  logic [NUM_CH-1:0] w_gnt;
  logic [7:0]      w_push_data;
  logic [7:0]      w_data_out;

  // ---------------------------------------------------------------------------
  // FIFO status and pop
  // ---------------------------------------------------------------------------
  assign w_ready = (r_count != '0);
  assign w_pop   = read & w_ready;

  // A full FIFO can still accept a byte when the same edge pops one.
  assign w_push_ok = (r_state == S_RUN) && ((r_count < L_DEPTH) || w_pop);

  // ---------------------------------------------------------------------------
  // Round-robin selection: scan from last+1, first set request wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_found     = 1'b0;
    w_cand      = 0;
    w_gnt_idx   = '0;
    w_push_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = (int'(r_last) + 1 + k) % NUM_CH;
      if (!w_found && req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_gnt_idx   = IDXW'(w_cand);
        w_push_data = req_data[w_cand*8 +: 8];
      end
    end
  end

  assign w_push = w_found & w_push_ok;

  always_comb begin
    w_gnt = '0;
    if (w_push) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (en) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (!en) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        // A returning enable takes priority over finishing the drain.
        if (en)                   w_next_state = S_RUN;
        else if (r_count == '0)   w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers, occupancy, grant history, status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_last   <= L_LAST_CH;
      r_hold   <= 8'h00;
      r_rd_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_last   <= w_gnt_idx;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Tracks what data_out shows so it can hold once the FIFO empties.
      r_hold   <= w_data_out;
      r_rd_err <= read & ~w_ready;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign w_data_out = w_ready ? r_mem[r_rd_ptr] : r_hold;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_gnt    = w_gnt;
  assign ready      = w_ready;
  assign data_out   = w_data_out;
  assign busy       = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign rd_err     = r_rd_err;
  assign dbg_state  = r_state;

endmodule
